// File: rtl/stack_rpn_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : stack_rpn_ctrl_if
// Description : Operation request/response and stack-command bundle for the
//               RPN stack controller. The slave side is the controller; the
//               master side is the requester together with the attached stack.
// Revision    : 1.0 - initial release
// ============================================================================
interface stack_rpn_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_data;
    logic       out_valid;
    logic [3:0] out_data;
    logic       err;
    logic [2:0] level;
    logic [1:0] s_command;
    logic [2:0] s_index;
    logic [3:0] s_i_data;
    logic [3:0] s_o_data;

    modport master (
        output in_valid, in_op, in_data, s_o_data,
        input  in_ready, out_valid, out_data, err, level,
               s_command, s_index, s_i_data
    );

    modport slave (
        input  in_valid, in_op, in_data, s_o_data,
        output in_ready, out_valid, out_data, err, level,
               s_command, s_index, s_i_data
    );
endinterface
`default_nettype wire

// File: rtl/stack_rpn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stack_rpn_ctrl
// Description : RPN calculator controller driving an attached stack
//               (LIT / ADD / SUB / PEEK). All outputs are registered.
//               Optional macro STACK_RPN_SAT_EN: ADD saturates at 15 and SUB
//               clamps at 0 instead of wrapping modulo 16.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_rpn_ctrl #(
    parameter int DEPTH = 5
) (
    input  wire logic        clk,
    input  wire logic        reset,
    stack_rpn_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUSH  = 3'd1,
        S_POP1  = 3'd2,
        S_POP2  = 3'd3,
        S_WAITB = 3'd4,
        S_GET   = 3'd5,
        S_WAITP = 3'd6
    } state_t;

    localparam logic [1:0] OP_LIT    = 2'b00;
    localparam logic [1:0] OP_ADD    = 2'b01;
    localparam logic [1:0] OP_SUB    = 2'b10;
    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_PUSH  = 2'b01;
    localparam logic [1:0] CMD_POP   = 2'b10;
    localparam logic [1:0] CMD_GET   = 2'b11;
    localparam logic [2:0] LEVEL_MAX = 3'(DEPTH);

    state_t     r_state;
    logic       r_in_ready;
    logic       r_out_valid;
    logic [3:0] r_out_data;
    logic       r_err;
    logic [2:0] r_level;
    logic [1:0] r_s_command;
    logic [2:0] r_s_index;
    logic [3:0] r_s_i_data;
    logic       r_op_sub;
    logic [3:0] r_a;

    // B arrives on s_o_data in WAITB; A (former top) was captured in POP2.
    logic [4:0] w_sum;
    logic [4:0] w_diff;
    logic [3:0] w_result;

    assign w_sum  = {1'b0, bus.s_o_data} + {1'b0, r_a};
    assign w_diff = {1'b0, bus.s_o_data} - {1'b0, r_a};

`ifdef STACK_RPN_SAT_EN
    // Saturating arithmetic: carry clips to 15, borrow clips to 0.
    always_comb begin
        w_result = 4'h0;
        if (r_op_sub)
            w_result = w_diff[4] ? 4'h0 : w_diff[3:0];
        else
            w_result = w_sum[4] ? 4'hF : w_sum[3:0];
    end
`else
    // Wrapping arithmetic modulo 16.
    always_comb begin
        w_result = 4'h0;
        if (r_op_sub)
            w_result = w_diff[3:0];
        else
            w_result = w_sum[3:0];
    end
`endif

    // Controller FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= 4'h0;
            r_err       <= 1'b0;
            r_level     <= 3'd0;
            r_s_command <= CMD_NOP;
            r_s_index   <= 3'd0;
            r_s_i_data  <= 4'h0;
            r_op_sub    <= 1'b0;
            r_a         <= 4'h0;
        end else begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_s_command <= CMD_NOP;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        case (bus.in_op)
                            OP_LIT: begin
                                if (r_level == LEVEL_MAX) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_state     <= S_PUSH;
                                    r_in_ready  <= 1'b0;
                                    r_s_command <= CMD_PUSH;
                                    r_s_i_data  <= bus.in_data;
                                    r_out_valid <= 1'b1;
                                    r_out_data  <= bus.in_data;
                                    r_level     <= r_level + 3'd1;
                                end
                            end
                            OP_ADD, OP_SUB: begin
                                // Pops come before the push, so a full stack is fine.
                                if (r_level < 3'd2) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_state     <= S_POP1;
                                    r_in_ready  <= 1'b0;
                                    r_s_command <= CMD_POP;
                                    r_op_sub    <= (bus.in_op == OP_SUB);
                                    r_level     <= r_level - 3'd1;
                                end
                            end
                            default: begin
                                if (bus.in_data[2:0] >= r_level) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_state     <= S_GET;
                                    r_in_ready  <= 1'b0;
                                    r_s_command <= CMD_GET;
                                    r_s_index   <= bus.in_data[2:0];
                                end
                            end
                        endcase
                    end
                end
                S_POP1: begin
                    r_state     <= S_POP2;
                    r_s_command <= CMD_POP;
                    r_level     <= r_level - 3'd1;
                end
                S_POP2: begin
                    r_state <= S_WAITB;
                    r_a     <= bus.s_o_data;
                end
                S_WAITB: begin
                    r_state     <= S_PUSH;
                    r_s_command <= CMD_PUSH;
                    r_s_i_data  <= w_result;
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_result;
                    r_level     <= r_level + 3'd1;
                end
                S_GET: begin
                    r_state <= S_WAITP;
                end
                S_WAITP: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b1;
                    r_out_data  <= bus.s_o_data;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.err       = r_err;
    assign bus.level     = r_level;
    assign bus.s_command = r_s_command;
    assign bus.s_index   = r_s_index;
    assign bus.s_i_data  = r_s_i_data;

endmodule
`default_nettype wire

// File: doc/stack_rpn_ctrl.md
STACK_RPN_CTRL -- requirements
Module: stack_rpn_ctrl

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 5, the capacity of the attached stack_behaviour_lite in entries (1..7).
REQ-002 CLK  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 RESET  input  1  reset, synchronous and active-high; the attached stack SHALL share CLK and RESET.
REQ-004 IN_VALID  input  1  operation request valid.
REQ-005 IN_READY  output  1  controller can accept an operation; a transfer occurs at an edge where IN_VALID=IN_READY=1.
REQ-006 IN_OP  input  2  operation: 00 LIT, 01 ADD, 10 SUB, 11 PEEK.
REQ-007 IN_DATA  input  4  literal for LIT; IN_DATA[2:0] is the index for PEEK.
REQ-008 OUT_VALID  output  1  one-cycle pulse: OUT_DATA valid.
REQ-009 OUT_DATA  output  4  operation result.
REQ-010 ERR  output  1  one-cycle pulse: operation rejected.
REQ-011 LEVEL  output  3  current stack occupancy, 0..DEPTH.
REQ-012 S_COMMAND  output  2  stack command: 00 NOP, 01 PUSH, 10 POP, 11 GET.
REQ-013 S_INDEX  output  3  stack GET index.
REQ-014 S_I_DATA  output  4  stack push data.
REQ-015 S_O_DATA  input  4  stack read data, valid in the cycle after the POP/GET cycle.

Function
REQ-016 Outputs SHALL be registered; S_COMMAND SHALL be NOP in every cycle not listed below.
REQ-017 FSM states SHALL be: IDLE, PUSH, POP1, POP2, WAITB, GET, WAITP; IN_READY=1 only in IDLE.
REQ-018 LIT accepted at edge N: cycle N+1 state PUSH, S_COMMAND=PUSH, S_I_DATA=IN_DATA, OUT_VALID=1, OUT_DATA=IN_DATA; LEVEL+1; IDLE at N+2.
REQ-019 ADD/SUB accepted at N: N+1 POP1 (POP); N+2 POP2 (POP), A=S_O_DATA captured at end of N+2; N+3 WAITB, B=S_O_DATA captured at end of N+3; N+4 PUSH with result, OUT_VALID=1, OUT_DATA=result; IDLE at N+5; net LEVEL-1.
REQ-020 ADD result SHALL be (B+A) mod 16; SUB result SHALL be (B-A) mod 16, where A is the former top and B the former second entry.
REQ-021 PEEK accepted at N: N+1 GET with S_INDEX=IN_DATA[2:0]; N+2 WAITP, capture S_O_DATA; N+3 IDLE with OUT_VALID=1, OUT_DATA=captured value; LEVEL unchanged.
REQ-022 LIT with LEVEL=DEPTH, ADD/SUB with LEVEL<2, or PEEK with index>=LEVEL SHALL be rejected: ERR=1 at N+1, no stack command, LEVEL unchanged, IDLE at N+1.
REQ-023 ERR and OUT_VALID SHALL never be asserted in the same cycle.
REQ-024 IN_VALID while IN_READY=0 SHALL have no effect; IN_OP/IN_DATA SHALL be sampled only at the accepting edge.
REQ-025 ADD/SUB with LEVEL=DEPTH SHALL succeed, because the two pops precede the push.

Reset
REQ-026 RESET=1 at an edge SHALL force IDLE, LEVEL=0, S_COMMAND=NOP, S_INDEX=0, S_I_DATA=0, OUT_VALID=0, OUT_DATA=0, ERR=0, and IN_READY=1 from the next cycle.
REQ-027 RESET during any non-IDLE state SHALL abort the operation with no OUT_VALID or ERR pulse.
REQ-028 RESET SHALL take priority over a simultaneous IN_VALID transfer.

Configuration
REQ-029 With STACK_RPN_SAT_EN defined, ADD SHALL saturate at 15 and SUB SHALL clamp at 0; without it, both SHALL wrap modulo 16 per REQ-020.

Verification
REQ-030 After reset, LIT 3, LIT 9, ADD -> PUSH 12 in the 4th cycle after ADD acceptance, OUT_DATA=12, LEVEL=1.
REQ-031 LIT 2, LIT 5, SUB -> OUT_DATA=13 with wrap, or 0 with STACK_RPN_SAT_EN; LIT 9, LIT 9, ADD -> 2 with wrap, or 15 with saturation.
REQ-032 Push 1..5 (DEPTH=5), then LIT 6 -> ERR pulse, no PUSH, LEVEL=5; then ADD -> OUT_DATA=9, LEVEL=4.
REQ-033 After LIT 1..4, PEEK 0..3 -> OUT_DATA 4,3,2,1 in that order, each 3 cycles after acceptance; PEEK 4 -> ERR.
REQ-034 Empty stack: ADD -> ERR; LIT 7 then ADD -> ERR, LEVEL=1.
REQ-035 RESET asserted in POP2 of an ADD -> next cycle IDLE, LEVEL=0, no OUT_VALID or ERR; subsequent PEEK 0 -> ERR.
